frame_buffer_reader: RTL and testbench

Display-side reader for the double-buffered SRAM frame buffer. The NFC drawing pipeline writes sprites into the frame selected by `even_frame`. This block streams the other, completed frame out of SRAM in raster order into a small word FIFO and unpacks 4-bit palette indices for the VGA colour mapper. It shares the SRAM with the writer through a simple request/grant arbiter at the top level.

---
 rtl/frame_buffer_reader_if.sv | 26 ++
 rtl/frame_buffer_reader.sv | 126 ++++++++++++
 tb/tb_frame_buffer_reader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_reader_if.sv
// Pixel stream and SRAM read-port bundle for the frame buffer reader.
// The master side is the reader itself.
interface frame_buffer_reader_if;
  logic        pixel_req;
  logic [3:0]  pixel_idx;
  logic        pixel_valid;
  logic        underflow;
  logic        sram_req;
  logic        sram_grant;
  logic [15:0] sram_dq;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [19:0] sram_address;

  modport master (
    input  pixel_req, sram_grant, sram_dq,
    output pixel_idx, pixel_valid, underflow,
    output sram_req, sram_oe_n, sram_we_n, sram_address
  );

  modport slave (
    output pixel_req, sram_grant, sram_dq,
    input  pixel_idx, pixel_valid, underflow,
    input  sram_req, sram_oe_n, sram_we_n, sram_address
  );
endinterface

// File: rtl/frame_buffer_reader.sv
// Streams the completed frame from SRAM into a word FIFO and unpacks 4-bit
// palette indices, four per 16-bit word, for the colour mapper.
module frame_buffer_reader #(
  parameter int          WIDTH       = 640,
  parameter int          HEIGHT      = 480,
  parameter logic [19:0] FRAME1_BASE = 20'h20000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_even_frame,
  input  logic i_frame_start,
  frame_buffer_reader_if.master io_bus
);
  localparam int WORDS = WIDTH * HEIGHT / 4;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_LATCH, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          r_disp_frame;
  logic [16:0]   r_word_cnt;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic [1:0]    r_sub;
  logic          r_underflow, r_sram_req, r_oe_n;
  logic [19:0]   r_addr;

  logic          w_push, w_pop, w_valid, w_last, w_req_nxt;
  logic [19:0]   w_base;
  logic [15:0]   w_head;

  assign w_valid = (r_count != '0);
  assign w_push  = (r_state == S_LATCH) && io_bus.sram_grant && !i_frame_start;
  assign w_pop   = io_bus.pixel_req && w_valid && (r_sub == 2'd3);
  assign w_last  = (r_word_cnt == 17'(WORDS - 1));
  assign w_base  = r_disp_frame ? FRAME1_BASE : 20'h0;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (i_frame_start)
      w_count_nxt = '0;
    else if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push)
      w_count_nxt = r_count - 1'b1;
  end

  always_comb begin
    w_next = r_state;
    if (i_frame_start) begin
      w_next = S_REQ;
    end else begin
      case (r_state)
        S_REQ:   if (r_sram_req && io_bus.sram_grant && i_en) w_next = S_ADDR;
        S_ADDR:  w_next = io_bus.sram_grant ? S_LATCH : S_REQ;
        S_LATCH: w_next = (io_bus.sram_grant && w_last) ? S_DONE : S_REQ;
        default: w_next = r_state;
      endcase
    end
  end

  // Request is registered, so it is computed from the post-edge state and
  // count; a single read in flight can never overfill the FIFO.
  assign w_req_nxt = (w_next == S_ADDR) || (w_next == S_LATCH) ||
                     ((w_next == S_REQ) && i_en &&
                      (w_count_nxt < (AW+1)'(FIFO_DEPTH)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_sram_req   <= 1'b0;
      r_oe_n       <= 1'b1;
      r_addr       <= '0;
      r_disp_frame <= 1'b0;
      r_word_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_sub        <= '0;
      r_underflow  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_sram_req <= w_req_nxt;
      r_oe_n     <= !((w_next == S_ADDR) || (w_next == S_LATCH));
      r_count    <= w_count_nxt;
      if (w_next == S_ADDR)
        r_addr <= w_base + {3'b000, r_word_cnt};
      if (i_frame_start) begin
        r_disp_frame <= ~i_even_frame;
        r_word_cnt   <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_sub        <= '0;
        r_underflow  <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_word_cnt <= r_word_cnt + 1'b1;
        end
        if (io_bus.pixel_req && w_valid)
          r_sub <= r_sub + 1'b1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        if (io_bus.pixel_req && !w_valid)
          r_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= io_bus.sram_dq;
  end

  assign io_bus.pixel_valid  = w_valid;
  assign io_bus.pixel_idx    = w_valid ? w_head[{r_sub, 2'b00} +: 4] : 4'h0;
  assign io_bus.underflow    = r_underflow;
  assign io_bus.sram_req     = r_sram_req;
  assign io_bus.sram_oe_n    = r_oe_n;
  assign io_bus.sram_we_n    = 1'b1;
  assign io_bus.sram_address = r_addr;
endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader; frame dimensions are reduced so a
// complete frame read fits in a short run.
module tb_frame_buffer_reader;
  localparam int          W     = 64;
  localparam int          H     = 8;
  localparam int          WORDS = W * H / 4;
  localparam logic [19:0] F1    = 20'h20000;

  logic clk = 1'b0;
  logic rst, en, even, fs;
  int   errors = 0;
  int   checks = 0;

  frame_buffer_reader_if bus();

  frame_buffer_reader #(
    .WIDTH(W), .HEIGHT(H), .FRAME1_BASE(F1), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_even_frame(even),
    .i_frame_start(fs), .io_bus(bus)
  );

  always #5 clk = ~clk;

  // SRAM model: word data is a fixed function of the address
  function automatic logic [15:0] mdl(input logic [19:0] a);
    return 16'h4321 + a[15:0];
  endfunction

  assign bus.sram_dq = mdl(bus.sram_address);

  // Log the address of every read that starts (OE_N falling)
  logic [19:0] rd_q[$];
  logic        prev_oe = 1'b1;
  always @(negedge clk) begin
    if (!bus.sram_oe_n && prev_oe) rd_q.push_back(bus.sram_address);
    prev_oe = bus.sram_oe_n;
  end

  typedef struct {
    logic       req;
    logic [3:0] idx;
    logic       valid;
  } vec_t;
  vec_t tv[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_low(input string nm);
    int n = 0;
    while (bus.sram_req && n < 200) begin tick(); n++; end
    chk(nm, 32'(n < 200), 32'd1);
  endtask

  task automatic pop_words(input string nm, input int nwords, input logic [19:0] a0);
    logic [15:0] d;
    for (int w = 0; w < nwords; w++) begin
      d = mdl(a0 + 20'(w));
      for (int k = 0; k < 4; k++) begin
        int n = 0;
        while (!bus.pixel_valid && n < 100) begin tick(); n++; end
        chk(nm, 32'(bus.pixel_idx), 32'(d[4*k +: 4]));
        bus.pixel_req = 1'b1;
        tick();
        bus.pixel_req = 1'b0;
      end
    end
  endtask

  initial begin
    int  n;
    logic stuck;
    tv[0] = '{1'b1, 4'h1, 1'b1};
    tv[1] = '{1'b1, 4'h2, 1'b1};
    tv[2] = '{1'b1, 4'h3, 1'b1};
    tv[3] = '{1'b1, 4'h4, 1'b1};

    rst = 1'b1; en = 1'b1; even = 1'b0; fs = 1'b0;
    bus.pixel_req = 1'b0; bus.sram_grant = 1'b1;
    tick(); tick();
    chk("rst_req",   32'(bus.sram_req),     32'd0);
    chk("rst_oe",    32'(bus.sram_oe_n),    32'd1);
    chk("rst_we",    32'(bus.sram_we_n),    32'd1);
    chk("rst_addr",  32'(bus.sram_address), 32'd0);
    chk("rst_valid", 32'(bus.pixel_valid),  32'd0);
    chk("rst_idx",   32'(bus.pixel_idx),    32'd0);
    chk("rst_uflow", 32'(bus.underflow),    32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_req", 32'(bus.sram_req), 32'd0);

    // Pop with nothing buffered
    bus.pixel_req = 1'b1; tick(); bus.pixel_req = 1'b0;
    chk("uflow_set", 32'(bus.underflow), 32'd1);

    // Fill from frame 1, no pops
    rd_q.delete();
    fs = 1'b1; tick(); fs = 1'b0;
    chk("fs_uflow_clr", 32'(bus.underflow), 32'd0);
    chk("fs_req",       32'(bus.sram_req),  32'd1);
    chk("fs_oe",        32'(bus.sram_oe_n), 32'd1);
    tick();
    chk("addr_oe0",     32'(bus.sram_oe_n),    32'd0);
    chk("addr_a0",      32'(bus.sram_address), 32'(F1));
    tick();
    chk("latch_oe0",    32'(bus.sram_oe_n),    32'd0);
    chk("latch_a0",     32'(bus.sram_address), 32'(F1));
    chk("latch_valid",  32'(bus.pixel_valid),  32'd0);
    tick();
    chk("push_oe1",     32'(bus.sram_oe_n),   32'd1);
    chk("first_valid",  32'(bus.pixel_valid), 32'd1);
    chk("first_idx",    32'(bus.pixel_idx),   32'd1);
    wait_req_low("fill_timeout");
    chk("fill_count", 32'(rd_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < rd_q.size(); i++)
      chk("fill_addr", 32'(rd_q[i]), 32'(F1) + 32'(i));
    tick(); tick(); tick(); tick(); tick();
    chk("full_req_low", 32'(bus.sram_req),  32'd0);
    chk("full_no_read", 32'(rd_q.size()), 32'd8);

    // Unpack word 0 (0x4321) pixel by pixel
    for (int i = 0; i < 4; i++) begin
      chk("pop_idx",   32'(bus.pixel_idx),   32'(tv[i].idx));
      chk("pop_valid", 32'(bus.pixel_valid), 32'(tv[i].valid));
      bus.pixel_req = tv[i].req;
      tick();
    end
    bus.pixel_req = 1'b0;
    chk("pop_refill_req", 32'(bus.sram_req), 32'd1);
    wait_req_low("refill_timeout");
    chk("refill_count", 32'(rd_q.size()), 32'd9);
    if (rd_q.size() == 9) chk("refill_addr", 32'(rd_q[8]), 32'(F1) + 32'd8);
    chk("next_head", 32'(bus.pixel_idx), 32'd2);

    // Grant drop during LATCH of word 5
    rd_q.delete();
    fs = 1'b1; tick(); fs = 1'b0;
    n = 0;
    while (rd_q.size() < 6 && n < 200) begin tick(); n++; end
    chk("gd_reach", 32'(n < 200), 32'd1);
    chk("gd_in_latch", 32'(bus.sram_oe_n), 32'd0);
    bus.sram_grant = 1'b0; tick(); bus.sram_grant = 1'b1;
    chk("gd_oe_off", 32'(bus.sram_oe_n), 32'd1);
    wait_req_low("gd_timeout");
    chk("gd_count", 32'(rd_q.size()), 32'd9);
    if (rd_q.size() == 9) begin
      chk("gd_reread5", 32'(rd_q[6]), 32'(F1) + 32'd5);
      chk("gd_addr8",   32'(rd_q[8]), 32'(F1) + 32'd7);
    end
    pop_words("gd_data", 8, F1);

    // Underflow then mid-frame flush to frame 0
    fs = 1'b1; tick(); fs = 1'b0;
    bus.pixel_req = 1'b1; tick(); bus.pixel_req = 1'b0;
    chk("uf2_set", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("uf2_filled", 32'(bus.pixel_valid), 32'd1);
    rd_q.delete();
    even = 1'b1; fs = 1'b1; tick(); fs = 1'b0;
    chk("flush_valid", 32'(bus.pixel_valid), 32'd0);
    chk("flush_uflow", 32'(bus.underflow),   32'd0);
    chk("flush_idx",   32'(bus.pixel_idx),   32'd0);
    n = 0;
    while (rd_q.size() < 1 && n < 50) begin tick(); n++; end
    chk("flush_addr", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hFFFF_FFFF, 32'd0);
    pop_words("f0_data", 2, 20'h0);

    // Whole frame with continuous pops
    even = 1'b0; rd_q.delete();
    fs = 1'b1; tick(); fs = 1'b0;
    n = 0;
    while (!(rd_q.size() >= WORDS && !bus.pixel_valid) && n < 5000) begin
      bus.pixel_req = bus.pixel_valid;
      tick(); n++;
    end
    bus.pixel_req = 1'b0;
    chk("frame_timeout", 32'(n < 5000), 32'd1);
    chk("frame_count", 32'(rd_q.size()), 32'(WORDS));
    if (rd_q.size() == WORDS) begin
      chk("frame_first", 32'(rd_q[0]),       32'(F1));
      chk("frame_last",  32'(rd_q[WORDS-1]), 32'(F1) + 32'(WORDS - 1));
    end
    stuck = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sram_req) stuck = 1'b1;
    end
    chk("done_no_req",  32'(stuck),          32'd0);
    chk("done_no_read", 32'(rd_q.size()),    32'(WORDS));
    chk("done_oe",      32'(bus.sram_oe_n),  32'd1);
    chk("done_uflow",   32'(bus.underflow),  32'd0);
    fs = 1'b1; tick(); fs = 1'b0;
    chk("restart_req", 32'(bus.sram_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
